// File: rtl/cnn_tile_sequencer.sv
// rtl/cnn_tile_sequencer.sv - tile sequencer: load a tile, wait out the PE/pool latency, emit the pooled result
module cnn_tile_sequencer #(
    parameter int PIPE_LAT = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] tile_count_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             buf_load_o,
    output logic [CNT_W-1:0] tile_idx_o,
    input  logic [15:0]      pool_in_i,
    output logic [15:0]      out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    localparam logic [3:0]       LAT     = 4'(PIPE_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] idx_q;
    logic [3:0]       lat_q;
    logic [15:0]      data_q;
    logic             done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (tile_count_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            count_q <= tile_count_i;
                            idx_q   <= '0;
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid_i) begin
                        lat_q   <= LAT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Counter reaching 1 marks the cycle Pool_In carries this tile's result.
                    lat_q <= lat_q - 4'd1;
                    if (lat_q == 4'd1) begin
                        data_q  <= pool_in_i;
                        state_q <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready_i) begin
                        if (idx_q == count_q - CNT_ONE) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + CNT_ONE;
                            state_q <= S_LOAD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == S_LOAD);
    assign buf_load_o  = (state_q == S_LOAD) && in_valid_i;
    assign out_valid_o = (state_q == S_EMIT);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign out_data_o  = data_q;
    assign tile_idx_o  = idx_q;

endmodule

// File: tb/tb_cnn_tile_sequencer.sv
// tb/tb_cnn_tile_sequencer.sv - self-checking bench for cnn_tile_sequencer
module tb_cnn_tile_sequencer;
    localparam int PL = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [CW-1:0] tile_count_i = '0;
    logic          in_valid_i = 1'b0;
    logic [15:0]   pool_in_i = '0;
    logic          out_ready_i = 1'b0;
    logic          in_ready_o, buf_load_o, out_valid_o, busy_o, done_o;
    logic [CW-1:0] tile_idx_o;
    logic [15:0]   out_data_o;

    cnn_tile_sequencer #(.PIPE_LAT(PL), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .tile_count_i(tile_count_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .buf_load_o(buf_load_o),
        .tile_idx_o(tile_idx_o), .pool_in_i(pool_in_i), .out_data_o(out_data_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: job bookkeeping by timestamps, not by FSM state.
    bit          m_known = 0;
    bit          m_job = 0;
    bit          m_flight = 0;
    int          m_count = 0;
    int          m_idx = 0;
    int          m_acc = 0;
    int          m_done_at = -1;
    logic [15:0] m_data = '0;

    int          hs_cnt = 0;
    int          done_cnt = 0;
    logic [15:0] hs_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic [CW-1:0] cnt,
                        input logic iv, input logic [15:0] pool, input logic ordy);
        bit e_busy, e_irdy, e_bl, e_ov, e_done;
        @(posedge clk);
        #1;
        cyc++;
        rst_i = rst; start_i = st; tile_count_i = cnt;
        in_valid_i = iv; pool_in_i = pool; out_ready_i = ordy;
        #1;
        e_busy = m_job;
        e_irdy = m_job && !m_flight;
        e_bl   = e_irdy && iv;
        e_ov   = m_flight && (cyc > m_acc + PL);
        e_done = (cyc == m_done_at);
        if (m_known) begin
            chk("busy", busy_o, e_busy);
            chk("in_ready", in_ready_o, e_irdy);
            chk("buf_load", buf_load_o, e_bl);
            chk("out_valid", out_valid_o, e_ov);
            chk("done", done_o, e_done);
            chk("tile_idx", tile_idx_o, m_idx);
            chk("out_data", out_data_o, m_data);
            chk("done_ov_excl", done_o && out_valid_o, 1'b0);
        end
        if (done_o === 1'b1) done_cnt++;
        if (out_valid_o === 1'b1 && ordy) begin
            hs_cnt++;
            hs_data.push_back(out_data_o);
        end
        if (rst) begin
            m_known = 1; m_job = 0; m_flight = 0; m_idx = 0; m_data = '0; m_done_at = -1;
        end else begin
            if (!m_job && st) begin
                if (cnt == 0) m_done_at = cyc + 1;
                else begin m_job = 1; m_count = cnt; m_idx = 0; end
            end
            if (e_bl) begin m_flight = 1; m_acc = cyc; end
            if (m_flight && cyc == m_acc + PL) m_data = pool;
            if (e_ov && ordy) begin
                m_flight = 0;
                if (m_idx == m_count - 1) begin m_job = 0; m_done_at = cyc + 1; end
                else m_idx++;
            end
        end
    endtask

    typedef struct {
        logic rst, st; logic [CW-1:0] cnt; logic iv; logic [15:0] pool; logic ordy;
        logic chk; logic irdy, bl, ov; logic [15:0] data; logic busy, done;
    } vec_t;
    vec_t tbl[12];
    logic [15:0] vals[4];
    int d0, h0;

    initial begin
        // Single tile, row index == cycle number from the reset cycle.
        tbl[0]  = '{1,0,0,0,16'h1111,1, 0, 0,0,0,16'h0000,0,0};
        tbl[1]  = '{0,0,0,0,16'h1111,1, 1, 0,0,0,16'h0000,0,0};
        tbl[2]  = '{0,1,1,0,16'h1111,1, 1, 0,0,0,16'h0000,0,0};
        tbl[3]  = '{0,0,0,0,16'h1111,1, 1, 1,0,0,16'h0000,1,0};
        tbl[4]  = '{0,0,0,0,16'h1111,1, 1, 1,0,0,16'h0000,1,0};
        tbl[5]  = '{0,0,0,1,16'h1111,1, 1, 1,1,0,16'h0000,1,0};
        tbl[6]  = '{0,0,0,1,16'h1111,1, 1, 0,0,0,16'h0000,1,0};
        tbl[7]  = '{0,0,0,0,16'h1111,1, 1, 0,0,0,16'h0000,1,0};
        tbl[8]  = '{0,0,0,0,16'h00A5,1, 1, 0,0,0,16'h0000,1,0};
        tbl[9]  = '{0,0,0,0,16'h2222,1, 1, 0,0,1,16'h00A5,1,0};
        tbl[10] = '{0,0,0,0,16'h3333,1, 1, 0,0,0,16'h00A5,0,1};
        tbl[11] = '{0,0,0,0,16'h4444,1, 1, 0,0,0,16'h00A5,0,0};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].st, tbl[i].cnt, tbl[i].iv, tbl[i].pool, tbl[i].ordy);
            if (tbl[i].chk) begin
                chk("tbl_in_ready", in_ready_o, tbl[i].irdy);
                chk("tbl_buf_load", buf_load_o, tbl[i].bl);
                chk("tbl_out_valid", out_valid_o, tbl[i].ov);
                chk("tbl_out_data", out_data_o, tbl[i].data);
                chk("tbl_busy", busy_o, tbl[i].busy);
                chk("tbl_done", done_o, tbl[i].done);
                chk("tbl_tile_idx", tile_idx_o, 0);
            end
        end

        // Four tiles 3,7,1,9.
        vals = '{16'd3, 16'd7, 16'd1, 16'd9};
        d0 = done_cnt;
        hs_data.delete();
        step(0, 1, 4, 0, 0, 1);
        for (int k = 0; k < 200 && m_job; k++) step(0, 0, 0, 1, vals[(m_idx < 4) ? m_idx : 0], 1);
        step(0, 0, 0, 0, 0, 1);
        chk("four_busy_end", busy_o, 0);
        chk("four_done_pulses", done_cnt - d0, 1);
        chk("four_hs_count", hs_data.size(), 4);
        if (hs_data.size() == 4)
            for (int k = 0; k < 4; k++) chk("four_hs_data", hs_data[k], vals[k]);

        // Backpressure: six stalled cycles in EMIT.
        d0 = done_cnt;
        step(0, 1, 1, 0, 16'hBEEF, 0);
        for (int k = 0; k < 20 && out_valid_o !== 1'b1; k++) step(0, 0, 0, 1, 16'hBEEF, 0);
        chk("bp_reached_emit", out_valid_o, 1);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 7, 1, 16'($urandom), 0);
            chk("bp_valid_held", out_valid_o, 1);
            chk("bp_data_held", out_data_o, 16'hBEEF);
            chk("bp_in_ready", in_ready_o, 0);
        end
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("bp_done", done_o, 1);
        chk("bp_done_pulses", done_cnt - d0, 1);

        // Zero-length job.
        d0 = done_cnt;
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("zero_done_pulses", done_cnt - d0, 1);

        // Start during WAIT is ignored.
        d0 = done_cnt; h0 = hs_cnt;
        step(0, 1, 2, 0, 0, 1);
        step(0, 0, 0, 1, 16'h0055, 1);
        step(0, 1, 5, 0, 16'h0055, 1);
        for (int k = 0; k < 100 && m_job; k++) step(0, 0, 0, 1, 16'($urandom), 1);
        step(0, 0, 0, 0, 0, 1);
        chk("ign_hs_count", hs_cnt - h0, 2);
        chk("ign_done_pulses", done_cnt - d0, 1);

        // Reset during WAIT of tile 2 of 4.
        d0 = done_cnt;
        step(0, 1, 4, 0, 0, 1);
        for (int k = 0; k < 100 && !(m_flight && m_idx == 1); k++) step(0, 0, 0, 1, 16'($urandom), 1);
        chk("rst_reached_tile2", tile_idx_o, 1);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_tile_idx", tile_idx_o, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_no_done", done_cnt - d0, 0);
        h0 = hs_cnt;
        step(0, 1, 2, 0, 0, 1);
        for (int k = 0; k < 100 && m_job; k++) step(0, 0, 0, 1, 16'($urandom), 1);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_new_hs", hs_cnt - h0, 2);
        chk("rst_new_done", done_cnt - d0, 1);

        // Maximum tile count.
        d0 = done_cnt; h0 = hs_cnt;
        step(0, 1, 8'hFF, 0, 0, 1);
        for (int k = 0; k < 3000 && m_job; k++) step(0, 0, 0, 1, 16'($urandom), 1);
        step(0, 0, 0, 0, 0, 1);
        chk("max_hs_count", hs_cnt - h0, 255);
        chk("max_done_pulses", done_cnt - d0, 1);
        chk("max_busy_end", busy_o, 0);

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++)
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                 CW'($urandom_range(0, 4)), 1'($urandom), 16'($urandom),
                 ($urandom_range(0, 9) < 6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
